// File: rtl/led_frame_buffer_if.sv
// CPU/debug-side write port of the LED frame buffer.
// wr_en and commit are single-cycle strobes sampled on every clock; there is no
// ready: every write is accepted, and busy stays high while a commit waits for a frame boundary.
interface led_frame_buffer_if;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       commit;
    logic       busy;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output commit,
        input  busy
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  commit,
        output busy
    );
endinterface

// File: rtl/led_frame_buffer.sv
// Double-buffered 4x8 LED column store with frame-synchronous commit and per-column blink.
// The front buffer only changes on a frame boundary, so the scan stage never shows a torn frame.
module led_frame_buffer #(
    parameter int FRAME_CYCLES = 4096,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                clk12MHz,
    input  logic                reset,
    led_frame_buffer_if.slave   cpu,
    output logic                frame_tick,
    output logic [7:0]          leds1,
    output logic [7:0]          leds2,
    output logic [7:0]          leds3,
    output logic [7:0]          leds4
);
    localparam int FW = $clog2(FRAME_CYCLES);
    localparam int BW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);
    localparam logic [FW-1:0] FRAME_ONE  = FW'(1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [BW-1:0] BLINK_HALF = BW'(BLINK_FRAMES / 2);
    localparam logic [BW-1:0] BLINK_ONE  = BW'(1);

    logic [FW-1:0] frame_cnt;
    logic [BW-1:0] blink_cnt;
    logic [7:0]    back  [4];
    logic [7:0]    front [4];
    logic [3:0]    blink_mask;
    logic          pending;
    logic          boundary;
    logic          off_phase;
    logic          col_write;
    logic          mask_write;

    assign boundary   = (frame_cnt == FRAME_LAST);
    assign off_phase  = (blink_cnt >= BLINK_HALF);
    assign col_write  = cpu.wr_en && (cpu.wr_addr[2] == 1'b0);
    assign mask_write = cpu.wr_en && (cpu.wr_addr == 3'd4);
    assign cpu.busy   = pending;

    // Frame and blink timebase; blink_cnt advances once per frame.
    always_ff @(posedge clk12MHz or posedge reset) begin
        if (reset) begin
            frame_cnt  <= '0;
            blink_cnt  <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= boundary;
            if (boundary) begin
                frame_cnt <= '0;
                blink_cnt <= (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + BLINK_ONE;
            end else begin
                frame_cnt <= frame_cnt + FRAME_ONE;
            end
        end
    end

    // Back buffer and blink mask are written directly by the CPU port.
    always_ff @(posedge clk12MHz or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                back[i] <= 8'h00;
            end
            blink_mask <= 4'h0;
        end else begin
            if (col_write) begin
                back[cpu.wr_addr[1:0]] <= cpu.wr_data;
            end
            if (mask_write) begin
                blink_mask <= cpu.wr_data[3:0];
            end
        end
    end

    // The copy samples back before this edge's write, so a same-cycle write waits for the next commit.
    always_ff @(posedge clk12MHz or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                front[i] <= 8'h00;
            end
            pending <= 1'b0;
        end else begin
            if (boundary && pending) begin
                for (int i = 0; i < 4; i++) begin
                    front[i] <= back[i];
                end
                pending <= 1'b0;
            end else if (cpu.commit) begin
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk12MHz or posedge reset) begin
        if (reset) begin
            leds1 <= 8'h00;
            leds2 <= 8'h00;
            leds3 <= 8'h00;
            leds4 <= 8'h00;
        end else begin
            leds1 <= (blink_mask[0] && off_phase) ? 8'h00 : front[0];
            leds2 <= (blink_mask[1] && off_phase) ? 8'h00 : front[1];
            leds3 <= (blink_mask[2] && off_phase) ? 8'h00 : front[2];
            leds4 <= (blink_mask[3] && off_phase) ? 8'h00 : front[3];
        end
    end
endmodule

// File: tb/tb_led_frame_buffer.sv
// Scoreboard bench for led_frame_buffer: a per-cycle reference model predicts every output
// sample, and a negedge monitor compares the DUT against the queued predictions.
module tb_led_frame_buffer;
    localparam int F = 64;
    localparam int B = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick;
    logic [7:0] leds1, leds2, leds3, leds4;

    led_frame_buffer_if bus ();

    led_frame_buffer #(
        .FRAME_CYCLES (F),
        .BLINK_FRAMES (B)
    ) dut (
        .clk12MHz   (clk),
        .reset      (reset),
        .cpu        (bus),
        .frame_tick (frame_tick),
        .leds1      (leds1),
        .leds2      (leds2),
        .leds3      (leds3),
        .leds4      (leds4)
    );

    always #5 clk = ~clk;

    // Scoreboard: {busy, frame_tick, leds4, leds3, leds2, leds1}
    logic [33:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0] m_back  [4];
    logic [7:0] m_front [4];
    logic [3:0] m_mask;
    bit         m_pending;
    int         cyc;

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t cyc=%0d: got %h expected %h", name, $time, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_back[i]  = 8'h00;
            m_front[i] = 8'h00;
        end
        m_mask    = 4'h0;
        m_pending = 1'b0;
        cyc       = 0;
    endtask

    // One clock edge of the reference: cyc counts edges since reset release.
    task automatic model_edge();
        bit         bnd;
        bit         off;
        logic [7:0] l [4];
        bnd = ((cyc % F) == F - 1);
        off = (((cyc / F) % B) >= B / 2);
        for (int n = 0; n < 4; n++) begin
            l[n] = (m_mask[n] && off) ? 8'h00 : m_front[n];
        end
        if (bnd && m_pending) begin
            for (int n = 0; n < 4; n++) begin
                m_front[n] = m_back[n];
            end
            m_pending = 1'b0;
        end else if (bus.commit) begin
            m_pending = 1'b1;
        end
        if (bus.wr_en && bus.wr_addr < 3'd4) begin
            m_back[bus.wr_addr[1:0]] = bus.wr_data;
        end
        if (bus.wr_en && bus.wr_addr == 3'd4) begin
            m_mask = bus.wr_data[3:0];
        end
        exp_q.push_back({m_pending, bnd, l[3], l[2], l[1], l[0]});
        cyc++;
    endtask

    always @(negedge clk) begin
        if (!reset && exp_q.size() != 0) begin
            check("outputs", {bus.busy, frame_tick, leds4, leds3, leds2, leds1}, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            model_edge();
        end
        #1;
        bus.wr_en  = 1'b0;
        bus.commit = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic write(input logic [2:0] a, input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        tick();
    endtask

    task automatic do_commit();
        bus.commit = 1'b1;
        tick();
    endtask

    task automatic to_phase(input int p);
        while ((cyc % F) != p) tick();
    endtask

    task automatic check_blank(input string name);
        check(name, {bus.busy, frame_tick, leds4, leds3, leds2, leds1}, 34'h0);
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_addr = 3'd0;
        bus.wr_data = 8'h00;
        bus.commit  = 1'b0;
        model_reset();
        #1 reset = 1'b1;
        #2 check_blank("reset_state");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();

        // Writes without commit must not reach the display
        write(3'd0, 8'h81);
        write(3'd1, 8'h42);
        write(3'd2, 8'h24);
        write(3'd3, 8'h18);
        run(3 * F);

        // Commit mid-frame, copy at the boundary
        to_phase(36);
        do_commit();
        run(2 * F);

        // Write on the boundary cycle itself is excluded from the copy
        write(3'd0, 8'h81);
        do_commit();
        to_phase(F - 1);
        write(3'd0, 8'hFF);
        run(F);
        do_commit();
        run(2 * F);

        // Commit on the boundary with nothing pending waits one more frame
        write(3'd1, 8'h5A);
        to_phase(F - 1);
        do_commit();
        run(2 * F);

        // Blink on column 2 only
        write(3'd1, 8'h42);
        do_commit();
        run(F);
        write(3'd4, 8'h02);
        run(3 * B * F);
        write(3'd4, 8'h00);

        // Randomised traffic, including ignored addresses and mask writes
        for (int i = 0; i < 3000; i++) begin
            bus.wr_en   = ($urandom_range(0, 3) == 0);
            bus.wr_addr = 3'($urandom_range(0, 7));
            bus.wr_data = 8'($urandom);
            bus.commit  = ($urandom_range(0, 39) == 0);
            tick();
        end
        bus.wr_en  = 1'b0;
        bus.commit = 1'b0;

        // Reset mid-frame with a commit pending
        write(3'd2, 8'hC3);
        do_commit();
        run(10);
        #2 reset = 1'b1;
        exp_q.delete();
        #1 check_blank("async_reset_blank");
        repeat (3) @(posedge clk);
        #1 check_blank("reset_held");
        reset = 1'b0;
        model_reset();
        run(2 * F + 5);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
